// File: rtl/vector_lane_sequencer.sv
// Sequences a V-bit vector operation through a shared L-bit lane ALU, one slice per beat.
// Latency: B+2 cycles from accepted StartVE to DoneVE release (accept, B beats, done).
// Backpressure: StallVE holds the pipeline from acceptance through RUN; FlushE aborts RUN.
module vector_lane_sequencer #(
    parameter int V = 256,
    parameter int L = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         StartVE,
    input  logic [2:0]   ALUControlE,
    input  logic [V-1:0] SrcAVE,
    input  logic [V-1:0] SrcBVE,
    input  logic         FlushE,
    output logic [L-1:0] LaneA,
    output logic [L-1:0] LaneB,
    output logic [2:0]   LaneCtrl,
    input  logic [L-1:0] LaneResult,
    output logic [V-1:0] ALUResultVE,
    output logic         StallVE,
    output logic         DoneVE,
    output logic         BusyVE
);

    localparam int B  = V / L;
    localparam int BW = (B > 1) ? $clog2(B) : 1;
    localparam int VW = (V > 1) ? $clog2(V) : 1;
    localparam logic [BW-1:0] LAST = BW'(B - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    typedef struct packed {
        logic [2:0]   ctrl;
        logic [V-1:0] a;
        logic [V-1:0] b;
    } op_t;

    state_t        state;
    logic [BW-1:0] beat;
    op_t           op_q;
    logic [V-1:0]  acc_q;
    logic [V-1:0]  acc_nxt;
    logic [V-1:0]  res_q;
    logic [VW-1:0] base;
    logic          busy_q;
    logic          done_q;
    logic          accept;

    assign base   = VW'(beat) * VW'(L);
    assign accept = (state == IDLE) && StartVE && !FlushE;

    // Partial slices collect in acc_q so a flushed operation never disturbs the visible result.
    always_comb begin
        acc_nxt             = acc_q;
        acc_nxt[base +: L]  = LaneResult;
    end

    always_comb begin
        LaneA    = '0;
        LaneB    = '0;
        LaneCtrl = '0;
        if (state == RUN) begin
            LaneA    = op_q.a[base +: L];
            LaneB    = op_q.b[base +: L];
            LaneCtrl = op_q.ctrl;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            beat   <= '0;
            op_q   <= '0;
            acc_q  <= '0;
            res_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (accept) begin
                        op_q.a    <= SrcAVE;
                        op_q.b    <= SrcBVE;
                        op_q.ctrl <= ALUControlE;
                        beat      <= '0;
                        busy_q    <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (FlushE) begin
                        beat   <= '0;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        acc_q <= acc_nxt;
                        if (beat == LAST) begin
                            res_q  <= acc_nxt;
                            beat   <= '0;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            state  <= DONE;
                        end else begin
                            beat <= beat + 1'b1;
                        end
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    beat   <= '0;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign ALUResultVE = res_q;
    assign BusyVE      = busy_q;
    assign DoneVE      = done_q;
    assign StallVE     = accept || (state == RUN);

endmodule

// File: tb/tb_vector_lane_sequencer.sv
// Bench for vector_lane_sequencer: elapsed-cycle reference model plus directed literal checks.
module tb_vector_lane_sequencer;

    localparam int V = 256;
    localparam int L = 64;
    localparam int B = V / L;

    logic         clk;
    logic         rst;
    logic         StartVE;
    logic [2:0]   ALUControlE;
    logic [V-1:0] SrcAVE;
    logic [V-1:0] SrcBVE;
    logic         FlushE;
    logic [L-1:0] LaneA;
    logic [L-1:0] LaneB;
    logic [2:0]   LaneCtrl;
    logic [L-1:0] LaneResult;
    logic [V-1:0] ALUResultVE;
    logic         StallVE;
    logic         DoneVE;
    logic         BusyVE;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    vector_lane_sequencer #(.V(V), .L(L)) dut (
        .clk(clk), .rst(rst), .StartVE(StartVE), .ALUControlE(ALUControlE),
        .SrcAVE(SrcAVE), .SrcBVE(SrcBVE), .FlushE(FlushE),
        .LaneA(LaneA), .LaneB(LaneB), .LaneCtrl(LaneCtrl), .LaneResult(LaneResult),
        .ALUResultVE(ALUResultVE), .StallVE(StallVE), .DoneVE(DoneVE), .BusyVE(BusyVE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [L-1:0] lane_alu(input logic [L-1:0] a, input logic [L-1:0] b,
                                              input logic [2:0] c);
        case (c)
            3'd0:    return a ^ b;
            3'd1:    return a;
            3'd2:    return a + b;
            3'd3:    return a & b;
            default: return a - b;
        endcase
    endfunction

    assign LaneResult = lane_alu(LaneA, LaneB, LaneCtrl);

    function automatic logic [V-1:0] vec_op(input logic [V-1:0] a, input logic [V-1:0] b,
                                            input logic [2:0] c);
        logic [V-1:0] r;
        r = '0;
        for (int i = 0; i < B; i++) r[i*L +: L] = lane_alu(a[i*L +: L], b[i*L +: L], c);
        return r;
    endfunction

    function automatic logic [V-1:0] rand_vec();
        logic [V-1:0] v;
        v = '0;
        for (int i = 0; i < V / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic chk(input string name, input logic [V-1:0] act, input logic [V-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: an accepted operation is described only by how many edges have passed.
    bit           m_active = 1'b0;
    int           m_t      = 0;
    logic [V-1:0] m_a      = '0;
    logic [V-1:0] m_b      = '0;
    logic [2:0]   m_code   = '0;
    logic [V-1:0] m_res    = '0;

    always @(posedge clk) begin
        if (!rst) begin
            m_active = 1'b0;
            m_t      = 0;
            m_res    = '0;
        end else if (!m_active) begin
            if (StartVE && !FlushE) begin
                m_active = 1'b1;
                m_t      = 1;
                m_a      = SrcAVE;
                m_b      = SrcBVE;
                m_code   = ALUControlE;
            end
        end else if (m_t <= B) begin
            if (FlushE) begin
                m_active = 1'b0;
            end else begin
                m_t++;
                if (m_t == B + 1) m_res = vec_op(m_a, m_b, m_code);
            end
        end else begin
            m_active = 1'b0;
        end
    end

    bit           e_run;
    bit           e_done;
    logic [7:0]   e_idx;
    logic [L-1:0] e_la;
    logic [L-1:0] e_lb;
    logic [2:0]   e_ctrl;

    always @(negedge clk) begin
        if (cmp_en) begin
            e_run  = m_active && (m_t <= B);
            e_done = m_active && (m_t == B + 1);
            e_idx  = e_run ? 8'((m_t - 1) * L) : 8'd0;
            e_la   = e_run ? m_a[e_idx +: L] : '0;
            e_lb   = e_run ? m_b[e_idx +: L] : '0;
            e_ctrl = e_run ? m_code : 3'd0;
            chk("busy", V'(BusyVE), V'(e_run));
            chk("done", V'(DoneVE), V'(e_done));
            chk("stall", V'(StallVE), V'(e_run || (!m_active && StartVE && !FlushE)));
            chk("lane_a", V'(LaneA), V'(e_la));
            chk("lane_b", V'(LaneB), V'(e_lb));
            chk("lane_ctrl", V'(LaneCtrl), V'(e_ctrl));
            chk("result", ALUResultVE, m_res);
        end
    end

    logic [V-1:0] a_nom, a_ord, ra, rb;
    logic [L-1:0] seq [4];
    int           done_cyc [8];
    int           n_done;

    initial begin
        rst = 1'b0; StartVE = 1'b0; FlushE = 1'b0; ALUControlE = '0; SrcAVE = '0; SrcBVE = '0;
        seq[0] = 64'hA; seq[1] = 64'hB; seq[2] = 64'hC; seq[3] = 64'hD;
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b1;
        cmp_en = 1'b1;

        @(negedge clk);
        chk("rst_stall", V'(StallVE), V'(1'b0));
        chk("rst_done", V'(DoneVE), V'(1'b0));
        chk("rst_busy", V'(BusyVE), V'(1'b0));
        chk("rst_result", ALUResultVE, '0);
        chk("rst_lane_a", V'(LaneA), '0);
        tick();

        // Nominal XOR operation against all ones.
        a_nom = {4{64'h0123456789ABCDEF}};
        SrcAVE = a_nom; SrcBVE = '1; ALUControlE = 3'd0; StartVE = 1'b1;
        for (int c = 0; c <= B + 1; c++) begin
            @(negedge clk);
            chk("nom_stall", V'(StallVE), V'(c <= B));
            chk("nom_done", V'(DoneVE), V'(c == B + 1));
            if (c == B + 1) chk("nom_result", ALUResultVE, ~a_nom);
            tick();
            StartVE = 1'b0;
        end

        // Beat ordering with a pass-through lane ALU.
        a_ord = {64'hD, 64'hC, 64'hB, 64'hA};
        SrcAVE = a_ord; SrcBVE = rand_vec(); ALUControlE = 3'd1; StartVE = 1'b1;
        tick();
        StartVE = 1'b0;
        for (int k = 0; k < B; k++) begin
            @(negedge clk);
            chk("ord_lane_a", V'(LaneA), V'(seq[k]));
            tick();
        end
        @(negedge clk);
        chk("ord_done", V'(DoneVE), V'(1'b1));
        chk("ord_result", ALUResultVE, a_ord);
        tick();

        // Flush in beat 2.
        SrcAVE = rand_vec(); SrcBVE = rand_vec(); ALUControlE = 3'd2; StartVE = 1'b1;
        tick();
        StartVE = 1'b0;
        tick();
        tick();
        FlushE = 1'b1;
        @(negedge clk);
        chk("flush_busy_before", V'(BusyVE), V'(1'b1));
        tick();
        FlushE = 1'b0;
        for (int c = 0; c < B + 2; c++) begin
            @(negedge clk);
            chk("flush_done", V'(DoneVE), V'(1'b0));
            chk("flush_busy", V'(BusyVE), V'(1'b0));
            chk("flush_stall", V'(StallVE), V'(1'b0));
            chk("flush_result", ALUResultVE, a_ord);
            tick();
        end

        // Start killed by a simultaneous flush.
        StartVE = 1'b1; FlushE = 1'b1;
        @(negedge clk);
        chk("kill_stall", V'(StallVE), V'(1'b0));
        chk("kill_busy", V'(BusyVE), V'(1'b0));
        tick();
        StartVE = 1'b0; FlushE = 1'b0;
        @(negedge clk);
        chk("kill_busy_after", V'(BusyVE), V'(1'b0));
        tick();

        // StartVE held high with operands changing every cycle.
        n_done = 0;
        StartVE = 1'b1;
        for (int k = 0; k < 3 * (B + 2); k++) begin
            SrcAVE = rand_vec(); SrcBVE = rand_vec(); ALUControlE = 3'($urandom_range(0, 4));
            @(negedge clk);
            if (DoneVE) begin
                if (n_done < 8) done_cyc[n_done] = k;
                n_done++;
            end
            tick();
        end
        StartVE = 1'b0;
        chk("hold_done_count", V'(n_done), V'(3));
        if (n_done >= 3) begin
            chk("hold_first_done", V'(done_cyc[0]), V'(B + 1));
            chk("hold_spacing_1", V'(done_cyc[1] - done_cyc[0]), V'(B + 2));
            chk("hold_spacing_2", V'(done_cyc[2] - done_cyc[1]), V'(B + 2));
        end
        repeat (B + 3) tick();

        // Reset during beat 1, then a clean operation.
        SrcAVE = rand_vec(); SrcBVE = rand_vec(); ALUControlE = 3'd0; StartVE = 1'b1;
        tick();
        StartVE = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_stall", V'(StallVE), '0);
        chk("mrst_done", V'(DoneVE), '0);
        chk("mrst_busy", V'(BusyVE), '0);
        chk("mrst_lane_a", V'(LaneA), '0);
        chk("mrst_lane_b", V'(LaneB), '0);
        chk("mrst_lane_ctrl", V'(LaneCtrl), '0);
        chk("mrst_result", ALUResultVE, '0);
        tick();
        ra = rand_vec(); rb = rand_vec();
        SrcAVE = ra; SrcBVE = rb; ALUControlE = 3'd3; StartVE = 1'b1;
        tick();
        StartVE = 1'b0;
        repeat (B) tick();
        @(negedge clk);
        chk("mrst_new_done", V'(DoneVE), V'(1'b1));
        chk("mrst_new_result", ALUResultVE, ra & rb);
        tick();

        // Randomized traffic including flushes and occasional resets.
        for (int k = 0; k < 3000; k++) begin
            rst         = ($urandom_range(0, 99) != 0);
            StartVE     = ($urandom_range(0, 2) == 0);
            FlushE      = ($urandom_range(0, 9) == 0);
            ALUControlE = 3'($urandom_range(0, 4));
            SrcAVE      = rand_vec();
            SrcBVE      = rand_vec();
            tick();
        end
        rst = 1'b1; StartVE = 1'b0; FlushE = 1'b0;
        repeat (B + 3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
